// File: rtl/sound_event_sequencer_if.sv
// Event requests, mute request and sound-controller outputs of sound_event_sequencer.
interface sound_event_sequencer_if;
  logic       ev_ping;
  logic       ev_pong;
  logic       ev_go;
  logic       ev_stop;
  logic       mute_in;
  logic [2:0] code_sound;
  logic       mute;
  logic       busy;
  logic [2:0] level;
  logic       overflow;

  modport master (
    output ev_ping, ev_pong, ev_go, ev_stop, mute_in,
    input  code_sound, mute, busy, level, overflow
  );

  modport slave (
    input  ev_ping, ev_pong, ev_go, ev_stop, mute_in,
    output code_sound, mute, busy, level, overflow
  );
endinterface

// File: rtl/sound_event_sequencer.sv
// Queues sound events in a 4-deep FIFO and plays each for TONE_CYCLES,
// separated by GAP_CYCLES of silence, driving a downstream sound controller.
module sound_event_sequencer #(
  parameter int unsigned TONE_CYCLES = 2000000,
  parameter int unsigned GAP_CYCLES  = 250000
) (
  input  logic                    clk,
  input  logic                    rst,
  sound_event_sequencer_if.slave  bus
);
  localparam logic [2:0] SILENT = 3'b100;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  fifo_q [4];
  logic [1:0]  fifo_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  level_q, level_d;
  logic        overflow_q, overflow_d;
  logic [2:0]  code_q, code_d;
  logic        mute_q, mute_d;
  logic        busy_q, busy_d;

  logic        ev_any;
  logic [1:0]  ev_code;
  logic [1:0]  head;
  logic        done;
  logic        pop;
  logic        push;
  logic        drop;

  always_comb begin
    ev_any = bus.ev_go | bus.ev_stop | bus.ev_ping | bus.ev_pong;
    // Stored code is the low two bits of the output code; bit 2 marks silence.
    if (bus.ev_go)        ev_code = 2'b11;
    else if (bus.ev_stop) ev_code = 2'b00;
    else if (bus.ev_ping) ev_code = 2'b10;
    else                  ev_code = 2'b01;

    head = fifo_q[rd_ptr_q];
    done = (cnt_q == '0);

    unique case (state_q)
      IDLE:    pop = (level_q != 3'd0);
      PLAY:    pop = done && (GAP_CYCLES == 0) && (level_q != 3'd0);
      GAP:     pop = done && (level_q != 3'd0);
      default: pop = 1'b0;
    endcase

    push = ev_any && ((level_q != 3'd4) || pop);
    drop = ev_any && (level_q == 3'd4) && !pop;

    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | drop;
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    mute_d     = mute_q;
    busy_d     = busy_q;

    if (push) begin
      fifo_d[wr_ptr_q] = ev_code;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    if (push && !pop)      level_d = level_q + 3'd1;
    else if (pop && !push) level_d = level_q - 3'd1;

    // Every pop starts a tone, whichever state it is taken from.
    if (pop) begin
      state_d = PLAY;
      cnt_d   = 32'(TONE_CYCLES - 1);
      code_d  = {1'b0, head};
      mute_d  = 1'b0;
      busy_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        PLAY: begin
          if (!done) begin
            cnt_d = cnt_q - 32'd1;
          end else if (GAP_CYCLES != 0) begin
            state_d = GAP;
            cnt_d   = 32'(GAP_CYCLES - 1);
            code_d  = SILENT;
            mute_d  = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            code_d  = SILENT;
            mute_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
        GAP: begin
          if (!done) begin
            cnt_d = cnt_q - 32'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            code_d  = SILENT;
            mute_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (bus.mute_in) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = overflow_q;
      state_d    = IDLE;
      cnt_d      = '0;
      code_d     = SILENT;
      mute_d     = 1'b1;
      busy_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      code_q     <= SILENT;
      mute_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      code_q     <= code_d;
      mute_q     <= mute_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.code_sound = code_q;
  assign bus.mute       = mute_q;
  assign bus.busy       = busy_q;
  assign bus.level      = level_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_sound_event_sequencer.sv
// Bench for sound_event_sequencer: scoreboard of expected tone codes plus
// cycle-exact checks of latency, FIFO fill, mute flush, reset and zero gap.
module tb_sound_event_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  logic prev_mute = 1'b1;
  int   dur = 0;
  logic [2:0] exp_q [$];

  sound_event_sequencer_if a ();
  sound_event_sequencer_if b ();

  sound_event_sequencer #(.TONE_CYCLES(4), .GAP_CYCLES(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  sound_event_sequencer #(.TONE_CYCLES(4), .GAP_CYCLES(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs applied just after the edge, outputs sampled at negedge.
  task automatic cyc(input logic [3:0] ev = 4'b0, input bit acc = 1'b0,
                     input bit m = 1'b0, input bit r = 1'b0, input bit evb = 1'b0);
    @(posedge clk);
    #1;
    a.ev_go   = ev[3];
    a.ev_stop = ev[2];
    a.ev_ping = ev[1];
    a.ev_pong = ev[0];
    a.mute_in = m;
    rst       = r;
    b.ev_ping = evb;
    if (acc) begin
      if (ev[3])      exp_q.push_back(3'b011);
      else if (ev[2]) exp_q.push_back(3'b000);
      else if (ev[1]) exp_q.push_back(3'b010);
      else            exp_q.push_back(3'b001);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((a.busy !== 1'b0 || a.level !== 3'd0) && n < max) begin
      cyc();
      n++;
    end
    check_eq("idle_wait", {31'b0, (a.busy === 1'b0 && a.level === 3'd0)}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_code"}, {29'b0, a.code_sound}, 32'h4);
    check_eq({tag, "_mute"}, {31'b0, a.mute}, 32'd1);
    check_eq({tag, "_busy"}, {31'b0, a.busy}, 32'd0);
    check_eq({tag, "_level"}, {29'b0, a.level}, 32'd0);
    check_eq({tag, "_ovf"}, {31'b0, a.overflow}, 32'd0);
  endtask

  // Scoreboard: every tone start pops the next expected code; full tones last 4 cycles.
  always @(negedge clk) begin
    if (mon_en) begin
      if (a.mute === 1'b0) begin
        if (prev_mute === 1'b1) begin
          check_eq("sb_pending", {31'b0, (exp_q.size() != 0)}, 32'd1);
          if (exp_q.size() != 0) check_eq("sb_code", {29'b0, a.code_sound}, {29'b0, exp_q.pop_front()});
          dur = 1;
        end else begin
          dur++;
        end
      end else if (prev_mute === 1'b0 && a.busy === 1'b1) begin
        check_eq("tone_len", dur, 32'd4);
      end
      prev_mute = a.mute;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    a.ev_go = 1'b0; a.ev_stop = 1'b0; a.ev_ping = 1'b0; a.ev_pong = 1'b0; a.mute_in = 1'b0;
    b.ev_go = 1'b0; b.ev_stop = 1'b0; b.ev_ping = 1'b0; b.ev_pong = 1'b0; b.mute_in = 1'b0;

    cyc(4'b0, 0, 0, 1);
    cyc(4'b0010, 0, 0, 1);
    check_reset_vals("reset");
    cyc();
    check_reset_vals("rst_evt_drop");
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) cyc();

    // Single ping: latency 2, 4 tone cycles, 2 gap cycles.
    cyc(4'b0010, 1);
    check_eq("ping_idle_mute", {31'b0, a.mute}, 32'd1);
    cyc();
    check_eq("ping_lvl1", {29'b0, a.level}, 32'd1);
    check_eq("ping_lat_mute", {31'b0, a.mute}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_eq("ping_code", {29'b0, a.code_sound}, 32'h2);
      check_eq("ping_mute", {31'b0, a.mute}, 32'd0);
      check_eq("ping_busy", {31'b0, a.busy}, 32'd1);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      check_eq("gap_code", {29'b0, a.code_sound}, 32'h4);
      check_eq("gap_mute", {31'b0, a.mute}, 32'd1);
      check_eq("gap_busy", {31'b0, a.busy}, 32'd1);
    end
    cyc();
    check_eq("after_gap_busy", {31'b0, a.busy}, 32'd0);

    // go + pong together: only go is queued.
    cyc(4'b1001, 1);
    cyc();
    check_eq("prio_lvl", {29'b0, a.level}, 32'd1);
    wait_idle(30);
    check_eq("prio_ovf", {31'b0, a.overflow}, 32'd0);

    // Six consecutive events: fill to 4, sixth dropped, then push+pop at full.
    cyc(4'b0010, 1);
    cyc(4'b0001, 1);
    cyc(4'b1000, 1);
    cyc(4'b0100, 1);
    cyc(4'b0010, 1);
    check_eq("fill_ovf_pre", {31'b0, a.overflow}, 32'd0);
    cyc(4'b0001, 0);
    check_eq("fill_lvl4", {29'b0, a.level}, 32'd4);
    cyc();
    check_eq("full_lvl", {29'b0, a.level}, 32'd4);
    check_eq("full_ovf", {31'b0, a.overflow}, 32'd1);
    cyc(4'b1000, 1);
    cyc();
    check_eq("pushpop_lvl", {29'b0, a.level}, 32'd4);
    wait_idle(100);
    check_eq("ovf_sticky", {31'b0, a.overflow}, 32'd1);

    cyc(4'b0, 0, 0, 1);
    cyc();
    check_reset_vals("ovf_clear");

    // mute_in in second PLAY cycle with level 2.
    cyc(4'b0010, 1);
    cyc(4'b0001, 0);
    cyc(4'b1000, 0);
    check_eq("mute_play", {31'b0, a.mute}, 32'd0);
    cyc(4'b0, 0, 1);
    check_eq("mute_pre_lvl", {29'b0, a.level}, 32'd2);
    check_eq("mute_pre_busy", {31'b0, a.busy}, 32'd1);
    cyc(4'b0001, 0, 1);
    check_reset_vals("flush");
    cyc(4'b0100, 1, 0);
    check_eq("flush_ign_lvl", {29'b0, a.level}, 32'd0);
    cyc();
    check_eq("unmute_acc_lvl", {29'b0, a.level}, 32'd1);
    wait_idle(30);

    // Reset during GAP with level 3, then a fresh event.
    cyc(4'b0010, 1);
    cyc(4'b0001, 0);
    cyc(4'b1000, 0);
    cyc(4'b0100, 0);
    cyc();
    cyc();
    cyc(4'b0010, 0, 0, 1);
    check_eq("gap_lvl3", {29'b0, a.level}, 32'd3);
    check_eq("gap_busy3", {31'b0, a.busy}, 32'd1);
    cyc();
    check_reset_vals("rst_gap");
    cyc(4'b0001, 1);
    cyc();
    check_eq("rel_lat_mute", {31'b0, a.mute}, 32'd1);
    cyc();
    check_eq("rel_code", {29'b0, a.code_sound}, 32'h1);
    check_eq("rel_mute", {31'b0, a.mute}, 32'd0);
    wait_idle(30);

    // Zero gap: two pings play back to back for 8 cycles.
    cyc(4'b0, 0, 0, 0, 1);
    cyc(4'b0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      check_eq("nogap_code", {29'b0, b.code_sound}, 32'h2);
      check_eq("nogap_mute", {31'b0, b.mute}, 32'd0);
    end
    cyc();
    check_eq("nogap_end_mute", {31'b0, b.mute}, 32'd1);
    check_eq("nogap_end_busy", {31'b0, b.busy}, 32'd0);
    check_eq("nogap_end_code", {29'b0, b.code_sound}, 32'h4);

    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
